// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator and later MAC stages.
// State encodings and the counter-width function live here so every stage agrees on them.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Minimum bit width to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder that clamps to all ones when the carry out is set.
// The sat output flags that clamping happened on this addition.
module sat_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sat = raw[W];
    assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a batch of N_TERMS unsigned products with saturation and presents the result
// over a valid/ready handshake; the accumulate half of a small MAC datapath.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PW      = 4,
    parameter int AW      = 8,
    parameter int N_TERMS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] product,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] sum,
    output logic          overflow
);

    localparam int            CW   = clog2(N_TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [AW-1:0] product_ext;
    logic [CW-1:0] count;
    logic          sat;

    assign product_ext = AW'(product);

    sat_adder #(
        .W(AW)
    ) u_sat_adder (
        .a  (acc),
        .b  (product_ext),
        .sum(acc_next),
        .sat(sat)
    );

    // Handshake flags decode only the state register, so neither depends
    // combinationally on in_valid or out_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign sum       = acc;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // Abort wins over any simultaneous input or output transfer.
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (state == ACCUM) begin
            if (in_valid && in_ready) begin
                acc      <= acc_next;
                overflow <= overflow | sat;
                count    <= count + CW'(1);
                if (count == LAST) begin
                    state <= HOLD;
                end
            end
        end else begin
            if (out_valid && out_ready) begin
                state    <= ACCUM;
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default config, a narrow AW=5 config
// and an N_TERMS=1 config, all sharing clock, reset and clear.
module tb_product_accumulator;

    logic clk;
    logic rst_n;
    logic clear;

    // Default configuration: PW=4, AW=8, N_TERMS=4
    logic       a_valid, a_ready, a_ovalid, a_oready, a_ovf;
    logic [3:0] a_prod;
    logic [7:0] a_sum;

    // Narrow accumulator: PW=4, AW=5, N_TERMS=4
    logic       b_valid, b_ready, b_ovalid, b_oready, b_ovf;
    logic [3:0] b_prod;
    logic [4:0] b_sum;

    // Single-term batches: PW=4, AW=8, N_TERMS=1
    logic       c_valid, c_ready, c_ovalid, c_oready, c_ovf;
    logic [3:0] c_prod;
    logic [7:0] c_sum;

    int compared;
    int mismatched;

    product_accumulator #(.PW(4), .AW(8), .N_TERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_valid), .in_ready(a_ready), .product(a_prod),
        .out_valid(a_ovalid), .out_ready(a_oready), .sum(a_sum), .overflow(a_ovf)
    );

    product_accumulator #(.PW(4), .AW(5), .N_TERMS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_valid), .in_ready(b_ready), .product(b_prod),
        .out_valid(b_ovalid), .out_ready(b_oready), .sum(b_sum), .overflow(b_ovf)
    );

    product_accumulator #(.PW(4), .AW(8), .N_TERMS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(c_valid), .in_ready(c_ready), .product(c_prod),
        .out_valid(c_ovalid), .out_ready(c_oready), .sum(c_sum), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [3:0] p);
        a_valid = 1'b1;
        a_prod  = p;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic feed_b(input logic [3:0] p);
        b_valid = 1'b1;
        b_prod  = p;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic rdy, input logic vld,
                           input logic [7:0] s, input logic ovf);
        check({tag, ".in_ready"},  32'(a_ready),  32'(rdy));
        check({tag, ".out_valid"}, 32'(a_ovalid), 32'(vld));
        check({tag, ".sum"},       32'(a_sum),    32'(s));
        check({tag, ".overflow"},  32'(a_ovf),    32'(ovf));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0; clear = 1'b0;
        a_valid = 1'b0; a_prod = '0; a_oready = 1'b1;
        b_valid = 1'b0; b_prod = '0; b_oready = 1'b1;
        c_valid = 1'b0; c_prod = '0; c_oready = 1'b1;
        #12;
        check_a("reset_a", 1'b1, 1'b0, 8'd0, 1'b0);
        check("reset_b.in_ready", 32'(b_ready), 32'd1);
        check("reset_c.out_valid", 32'(c_ovalid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Batch 9,4,1,6 with consumer ready: result one cycle after the last transfer.
        feed_a(4'd9);
        feed_a(4'd4);
        check_a("partial_13", 1'b1, 1'b0, 8'd13, 1'b0);
        feed_a(4'd1);
        feed_a(4'd6);
        check_a("batch_20", 1'b0, 1'b1, 8'd20, 1'b0);
        tick();
        check_a("after_handshake_20", 1'b1, 1'b0, 8'd0, 1'b0);

        // Batch 9,9,9,9 stalled by the consumer for five cycles.
        a_oready = 1'b0;
        repeat (4) feed_a(4'd9);
        check_a("batch_36", 1'b0, 1'b1, 8'd36, 1'b0);
        a_valid = 1'b1;
        a_prod  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a($sformatf("stall_%0d", i), 1'b0, 1'b1, 8'd36, 1'b0);
        end
        a_valid  = 1'b0;
        a_oready = 1'b1;
        tick();
        check_a("after_stall", 1'b1, 1'b0, 8'd0, 1'b0);

        // Clear alongside a valid product discards partials and that product.
        feed_a(4'd3);
        feed_a(4'd5);
        check_a("partial_8", 1'b1, 1'b0, 8'd8, 1'b0);
        clear   = 1'b1;
        a_valid = 1'b1;
        a_prod  = 4'd7;
        tick();
        clear   = 1'b0;
        a_valid = 1'b0;
        check_a("after_clear", 1'b1, 1'b0, 8'd0, 1'b0);
        repeat (4) feed_a(4'd2);
        check_a("batch_8", 1'b0, 1'b1, 8'd8, 1'b0);
        tick();

        // Clear in HOLD with consumer ready drops the pending result.
        a_oready = 1'b0;
        repeat (4) feed_a(4'd1);
        check_a("hold_4", 1'b0, 1'b1, 8'd4, 1'b0);
        a_oready = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        check_a("clear_in_hold", 1'b1, 1'b0, 8'd0, 1'b0);

        // Asynchronous reset mid-batch, asserted and released between edges.
        repeat (3) feed_a(4'd1);
        check_a("partial_3", 1'b1, 1'b0, 8'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_reset", 1'b1, 1'b0, 8'd0, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        feed_a(4'd1);
        feed_a(4'd2);
        feed_a(4'd3);
        feed_a(4'd3);
        check_a("batch_9", 1'b0, 1'b1, 8'd9, 1'b0);
        tick();

        // AW=5: 9+9+9 = 27 fits, the fourth saturates at 31 and flags overflow.
        feed_b(4'd9);
        feed_b(4'd9);
        feed_b(4'd9);
        check("b_partial.sum", 32'(b_sum), 32'd27);
        check("b_partial.overflow", 32'(b_ovf), 32'd0);
        feed_b(4'd9);
        check("b_sat.out_valid", 32'(b_ovalid), 32'd1);
        check("b_sat.sum", 32'(b_sum), 32'd31);
        check("b_sat.overflow", 32'(b_ovf), 32'd1);
        tick();
        check("b_after.overflow", 32'(b_ovf), 32'd0);
        check("b_after.in_ready", 32'(b_ready), 32'd1);
        repeat (4) feed_b(4'd1);
        check("b_next.sum", 32'(b_sum), 32'd4);
        check("b_next.overflow", 32'(b_ovf), 32'd0);
        check("b_next.out_valid", 32'(b_ovalid), 32'd1);
        tick();

        // N_TERMS=1: back-to-back products with in_valid held high.
        c_valid = 1'b1;
        c_prod  = 4'd6;
        tick();
        check("c_first.out_valid", 32'(c_ovalid), 32'd1);
        check("c_first.sum", 32'(c_sum), 32'd6);
        check("c_first.in_ready", 32'(c_ready), 32'd0);
        c_prod = 4'd2;
        tick();
        check("c_handshake.out_valid", 32'(c_ovalid), 32'd0);
        check("c_handshake.in_ready", 32'(c_ready), 32'd1);
        check("c_handshake.sum", 32'(c_sum), 32'd0);
        tick();
        c_valid = 1'b0;
        check("c_second.out_valid", 32'(c_ovalid), 32'd1);
        check("c_second.sum", 32'(c_sum), 32'd2);
        tick();
        check("c_done.out_valid", 32'(c_ovalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
